// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// The byte stream is a little-endian word count followed by little-endian words.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Collects bytes LSB first into an instruction word; word_valid pulses
// combinationally on the byte that completes the word.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]                  byte_idx;
  logic [8*(BYTES_PER_WORD-1)-1:0]   asm_q;

  // The final byte is never stored: it goes straight into the word output.
  assign word_valid = byte_en && (byte_idx == LAST_IDX);
  assign word       = {byte_in, asm_q};

  always_ff @(posedge clk) begin
    if (clear) begin
      byte_idx <= '0;
      asm_q    <= '0;
    end else if (byte_en) begin
      if (word_valid) begin
        byte_idx <= '0;
      end else begin
        asm_q[byte_idx*8 +: 8] <= byte_in;
        byte_idx               <= byte_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it to instruction
// memory from word 0, and keeps the CPU in reset until the image is complete.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  load_start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded,
  output state_t                dbg_state
);

  // Handshake: a byte moves on any rising edge where in_valid && in_ready;
  // in_ready is registered and is high exactly in LEN0, LEN1 and DATA.

  localparam int LEN_W = 8 * LEN_BYTES;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W:0]   MAX_WORDS = (LEN_W+1)'(2 ** ADDR_WIDTH);

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_full;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W-1:0]   tmo_next;
  logic               tmo_expired;
  logic               xfer;
  logic               byte_en;
  logic               restart;
  logic               timeout_hit;
  logic               asm_clear;
  logic               word_valid;
  logic [31:0]        word;
  logic               last_word;

  assign xfer        = in_valid && in_ready;
  assign byte_en     = xfer && (state == DATA);
  assign len_full    = {in_data, len[7:0]};
  assign tmo_expired = (tmo_cnt == TMO_LAST);
  assign last_word   = ((words_loaded + 16'd1) == len);
  assign asm_clear   = reset || timeout_hit || restart;
  assign dbg_state   = state;

  word_assembler u_asm (
    .clk        (clk),
    .clear      (asm_clear),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= LEN0;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    tmo_next    = tmo_cnt;
    restart     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      LEN0: begin
        tmo_next = '0;
        if (xfer) state_next = LEN1;
      end
      LEN1: begin
        if (xfer) begin
          tmo_next = '0;
          if (len_full == '0)                       state_next = DONE;
          else if ({1'b0, len_full} > MAX_WORDS)    state_next = ERROR;
          else                                      state_next = DATA;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          tmo_next    = '0;
          state_next  = ERROR;
        end else begin
          tmo_next = tmo_cnt + 1'b1;
        end
      end
      DATA: begin
        if (xfer) begin
          tmo_next = '0;
          if (word_valid && last_word) state_next = DONE;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          tmo_next    = '0;
          state_next  = ERROR;
        end else begin
          tmo_next = tmo_cnt + 1'b1;
        end
      end
      DONE, ERROR: begin
        tmo_next = '0;
        if (load_start) begin
          restart    = 1'b1;
          state_next = LEN0;
        end
      end
      default: state_next = LEN0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      tmo_cnt      <= '0;
    end else begin
      in_ready <= (state_next == LEN0) || (state_next == LEN1) || (state_next == DATA);
      imem_we  <= word_valid;
      tmo_cnt  <= tmo_next;
      if (word_valid) begin
        imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
        imem_wdata   <= word;
        words_loaded <= words_loaded + 16'd1;
      end
      if (xfer && (state == LEN0)) len[7:0]  <= in_data;
      if (xfer && (state == LEN1)) len[15:8] <= in_data;
      if (restart) begin
        cpu_reset    <= 1'b1;
        load_done    <= 1'b0;
        load_error   <= 1'b0;
        words_loaded <= '0;
      end else begin
        // Release one edge after DONE entry so the last write lands first.
        if (state == DONE) cpu_reset <= 1'b0;
        if ((state_next == DONE) && (state != DONE)) load_done <= 1'b1;
        if (state_next == ERROR) load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a per-cycle vector table plus hand-written
// sequences for gapped input and timeout recovery, with a write scoreboard.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        load_start;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  dat;
    logic        st;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        crst;
    logic        rdy;
    logic [15:0] wl;
    state_t      state;
  } vec_t;

  vec_t vecs[$];

  instr_loader #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load_start   (load_start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: test did not complete in time");
    $fatal(1, "watchdog");
  end

  // scoreboard for memory writes
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: got unexpected write addr=%h data=%h, required none", imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL sb_write: got %h, required %h", {imem_addr, imem_wdata}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int waited;
    bit sent;
    waited = 0;
    sent = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!sent && waited < 50) begin
      if (in_ready === 1'b1) sent = 1;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    if (!sent) check("send_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic add(input logic rst, input logic vld, input logic [7:0] dat, input logic st,
                     input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic done, input logic err, input logic crst, input logic rdy,
                     input logic [15:0] wl, input state_t s);
    vec_t v;
    v.rst = rst; v.vld = vld; v.dat = dat; v.st = st;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.done = done; v.err = err; v.crst = crst; v.rdy = rdy; v.wl = wl; v.state = s;
    vecs.push_back(v);
  endtask

  // Full two-word image from LEN0, with valid held high, then one idle cycle.
  task automatic add_image();
    add(0, 1, 8'h02, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd0, LEN1);
    add(0, 1, 8'h00, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'h13, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'h05, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'hA0, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'h00, 0,  1, 8'h00, 32'h00A00513,   0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h93, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h05, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h50, 0,  0, 8'h00, 32'h0,          0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h00, 0,  1, 8'h01, 32'h00500593,   1, 0, 1, 0, 16'd2, DONE);
    add(0, 0, 8'h00, 0,  0, 8'h00, 32'h0,          1, 0, 0, 0, 16'd2, DONE);
  endtask

  task automatic add_reset_vec(input logic vld, input logic st);
    add(1, vld, 8'h00, st,  0, 8'h00, 32'h0,  0, 0, 1, 1, 16'd0, LEN0);
  endtask

  task automatic add_restart(input logic err_state);
    add(0, 0, 8'h00, 1,  0, 8'h00, 32'h0,  0, 0, 1, 1, 16'd0, LEN0);
  endtask

  logic [7:0] img [10];

  initial begin
    logic [63:0] exp_v;
    logic [63:0] act_v;
    logic        bus;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; load_start = 1'b0;

    // reset and nominal load
    add_reset_vec(0, 0);
    add_image();
    // reload from DONE
    add_restart(0);
    // zero length
    add(0, 1, 8'h00, 0,  0, 8'h00, 32'h0,  0, 0, 1, 1, 16'd0, LEN1);
    add(0, 1, 8'h00, 0,  0, 8'h00, 32'h0,  1, 0, 1, 0, 16'd0, DONE);
    add(0, 0, 8'h00, 0,  0, 8'h00, 32'h0,  1, 0, 0, 0, 16'd0, DONE);
    add_restart(0);
    // oversize N=257, byte offered in ERROR is not taken
    add(0, 1, 8'h01, 0,  0, 8'h00, 32'h0,  0, 0, 1, 1, 16'd0, LEN1);
    add(0, 1, 8'h01, 0,  0, 8'h00, 32'h0,  0, 1, 1, 0, 16'd0, ERROR);
    add(0, 1, 8'h13, 0,  0, 8'h00, 32'h0,  0, 1, 1, 0, 16'd0, ERROR);
    add_restart(1);
    // N=256 accepted
    add(0, 1, 8'h00, 0,  0, 8'h00, 32'h0,  0, 0, 1, 1, 16'd0, LEN1);
    add(0, 1, 8'h01, 0,  0, 8'h00, 32'h0,  0, 0, 1, 1, 16'd0, DATA);
    add_reset_vec(0, 0);
    // reset mid-load on the edge that would complete word 1; load_start in DATA ignored
    add(0, 1, 8'h02, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd0, LEN1);
    add(0, 1, 8'h00, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'h13, 1,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'h05, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'hA0, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd0, DATA);
    add(0, 1, 8'h00, 0,  1, 8'h00, 32'h00A00513,  0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h93, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h05, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd1, DATA);
    add(0, 1, 8'h50, 0,  0, 8'h00, 32'h0,         0, 0, 1, 1, 16'd1, DATA);
    add_reset_vec(1, 0);
    add_image();
    // reset beats load_start
    add_reset_vec(0, 1);
    add_image();
    add_restart(0);
    add_image();

    foreach (vecs[i]) begin
      if (vecs[i].we) exp_q.push_back({vecs[i].addr, vecs[i].wdata});
    end

    for (int i = 0; i < vecs.size(); i++) begin
      reset      = vecs[i].rst;
      in_valid   = vecs[i].vld;
      in_data    = vecs[i].dat;
      load_start = vecs[i].st;
      tick();
      bus   = vecs[i].we || vecs[i].rst;
      exp_v = {vecs[i].we, bus ? vecs[i].addr : 8'h00, bus ? vecs[i].wdata : 32'h0,
               vecs[i].done, vecs[i].err, vecs[i].crst, vecs[i].rdy, vecs[i].wl, vecs[i].state};
      act_v = {imem_we, bus ? imem_addr : 8'h00, bus ? imem_wdata : 32'h0,
               load_done, load_error, cpu_reset, in_ready, words_loaded, dbg_state};
      check($sformatf("vec_%0d", i), act_v, exp_v);
    end
    reset = 1'b0; in_valid = 1'b0; load_start = 1'b0;

    // timeout after a partial word, then recovery
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h05);
    repeat (15) tick();
    check("tmo_before", 64'(load_error), 64'd0);
    tick();
    check("tmo_error", {61'd0, load_error, cpu_reset, in_ready}, {61'd0, 1'b1, 1'b1, 1'b0});
    check("tmo_state", 64'(dbg_state), 64'(ERROR));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("tmo_restart", {61'd0, load_error, cpu_reset, in_ready}, {61'd0, 1'b0, 1'b1, 1'b1});
    exp_q.push_back({8'h00, 32'h00000137});
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h37); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    check("tmo_recover_done", {47'd0, load_done, words_loaded}, {47'd0, 1'b1, 16'd1});
    tick();
    check("tmo_recover_cpu", 64'(cpu_reset), 64'd0);

    // gapped input, gaps kept below the 16-cycle timeout
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    do_reset();
    exp_q.push_back({8'h00, 32'h00A00513});
    exp_q.push_back({8'h01, 32'h00500593});
    for (int i = 0; i < 10; i++) begin
      send_byte(img[i]);
      if (i < 9) repeat ($urandom_range(3, 14)) tick();
    end
    check("gap_done", {46'd0, load_done, cpu_reset, words_loaded}, {46'd0, 1'b1, 1'b1, 16'd2});
    tick();
    check("gap_release", {62'd0, cpu_reset, in_ready}, {62'd0, 1'b0, 1'b0});
    check("gap_state", 64'(dbg_state), 64'(DONE));

    tick();
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
